vx_issue_scoreboard_rr: RTL and testbench
=========================================

// Module: vx_issue_scoreboard_rr
// PURPOSE
//  Parametrised issue-stage successor: per-warp instruction streams from the ibuffer pass through
//  a register-pending scoreboard. A round-robin arbiter then picks one hazard-free warp per cycle
//  into a registered dispatch stage, which is steered to NUM_EX execution units. Multi-port
//  writeback releases pending registers. Sits between ibuffer and operand collector.
// PARAMETERS
//  NUM_WARPS     4   warp streams arbitrated (>=1)
//  NUM_REGS      64  architectural regs per warp; RW = $clog2(NUM_REGS)
//  NUM_WB        2   writeback ports, each may release one reg per cycle
//  NUM_EX        4   execution units; EXW = $clog2(NUM_EX), min 1
//  DATAW         64  opaque per-instruction payload (uuid, PC, op, ...)
//  PERF_CTR_BITS 44  width of stall / issue counters
// PORTS
//  clk            in   1                clock
//  reset          in   1                synchronous, active-high
//  in_valid       in   NUM_WARPS        per-warp instruction valid
//  in_ready       out  NUM_WARPS        per-warp accept (one-hot or zero)
//  in_wb          in   NUM_WARPS        instruction writes rd
//  in_rd/rs1/rs2/rs3 in NUM_WARPS*RW    register indices, warp w at [w*RW +: RW]
//  in_ex_type     in   NUM_WARPS*EXW    target unit
//  in_data        in   NUM_WARPS*DATAW  payload
//  wb_valid       in   NUM_WB           writeback strobe
//  wb_wid         in   NUM_WB*WIDW      warp id; WIDW = max(1,$clog2(NUM_WARPS))
//  wb_rd          in   NUM_WB*RW        released reg
//  wb_eop         in   NUM_WB           last packet of instruction; release only when set
//  out_valid      out  NUM_EX           one-hot dispatch valid (bit = held ex_type)
//  out_ready      in   NUM_EX           per-unit ready
//  out_wid        out  WIDW             held warp id
//  out_data       out  DATAW            held payload
//  perf_stalls    out  PERF_CTR_BITS    cycles with >=1 valid warp but no grant
//  perf_issued    out  PERF_CTR_BITS    instructions granted
// BEHAVIOUR
//  - Reset: pending table all 0, out_valid 0, out_wid/out_data 0, rr pointer 0, counters 0.
//    Held instruction is dropped. in_ready is 0 during reset.
//  - Release: rel[w][r] = OR over ports p of wb_valid[p] & wb_eop[p] & wb_wid==w & wb_rd==r.
//    Releases apply to this cycle's hazard check (same-cycle bypass).
//  - Hazard[w] = pend'[w][rs1]|pend'[w][rs2]|pend'[w][rs3]|(in_wb[w]&pend'[w][rd]),
//    where pend' = pend & ~rel. Register index 0 is never pending (hardwired zero).
//  - Stage load: load_ok = ~out_valid_any | out_ready[held ex_type].
//  - eligible[w] = in_valid[w] & ~hazard[w] & load_ok. The grant is one-hot round-robin over
//    eligible, priority starting at rr_ptr. in_ready = grant, combinational and same cycle.
//  - rr_ptr <= (granted w + 1) mod NUM_WARPS on grant; holds otherwise.
//  - Latency: granted at cycle N -> out_valid at N+1. Output is held stable until out_ready of
//    its unit. Back-to-back issue occurs when fire and grant land in the same cycle.
//  - Pending update per cycle: pend <= (pend & ~rel) | set, where set = grant & in_wb & rd!=0.
//    When set and rel hit the same reg, set wins (new producer).
//  - A release to a non-pending reg is a no-op; simulation asserts. Duplicate releases across
//    ports in the same cycle are OR-ed.
//  - perf_stalls += (|in_valid & ~|grant); perf_issued += |grant. Both wrap modulo 2^PERF_CTR_BITS.
//  - in_ex_type >= NUM_EX is illegal; simulation asserts.
// STRUCTURE
//  - vx_issue_pkg: RW/WIDW/EXW localparams, issue_req_t {wb, rd, rs1, rs2, rs3, ex_type, data}.
//  - One sub-module, vx_rr_arbiter #(N): req -> one-hot grant plus pointer update. Scoreboard
//    table, release decode, dispatch register and counters stay inline.
// TESTING
//  1. Reset, then warp0 issues wb rd=5, ex=1 -> out_valid=4'b0010 next cycle, pend[0][5]=1;
//     warp0 follows with rs1=5 -> in_ready[0]=0, perf_stalls increments each cycle.
//  2. With pend[0][5] set, wb_valid=1, wid=0, rd=5, eop=1 in the same cycle as a warp0 rs1=5
//     request -> granted that cycle (bypass). With eop=0 -> not granted.
//  3. All 4 warps valid and hazard-free, out_ready all 1 -> grants 0,1,2,3,0 on consecutive
//     cycles; perf_issued=5.
//  4. out_ready[ex]=0 for 3 cycles -> out_data/out_wid stable, in_ready=0. Release ready ->
//     fire and a new grant occur in the same cycle.
//  5. Grant with wb rd=7 coincident with a wb release of rd=7 for the same warp -> pend[w][7]=1
//     afterwards. rd=0 with wb=1 -> never pending.
//  6. Assert reset while out_valid=1 and regs pending -> next cycle out_valid=0, table clear,
//     rr_ptr=0, counters 0.

Source files
------------

// File: rtl/vx_issue_scoreboard_rr_pkg.sv
// Shared defaults, derived widths and the issue request layout for the
// scoreboarded round-robin issue stage.
package vx_issue_scoreboard_rr_pkg;

    localparam int DEF_NUM_WARPS     = 4;
    localparam int DEF_NUM_REGS      = 64;
    localparam int DEF_NUM_WB        = 2;
    localparam int DEF_NUM_EX        = 4;
    localparam int DEF_DATAW         = 64;
    localparam int DEF_PERF_CTR_BITS = 44;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_RW   = $clog2(DEF_NUM_REGS);
    localparam int DEF_WIDW = clog2_min1(DEF_NUM_WARPS);
    localparam int DEF_EXW  = clog2_min1(DEF_NUM_EX);

    // Request layout at the default configuration; the top re-declares it with its own widths.
    typedef struct packed {
        logic                 wb;
        logic [DEF_RW-1:0]    rd;
        logic [DEF_RW-1:0]    rs1;
        logic [DEF_RW-1:0]    rs2;
        logic [DEF_RW-1:0]    rs3;
        logic [DEF_EXW-1:0]   ex_type;
        logic [DEF_DATAW-1:0] data;
    } issue_req_t;

endpackage

// File: rtl/vx_issue_scoreboard_rr_if.sv
// Bundle of ibuffer request, writeback release, dispatch and perf signals.
// master drives instructions/writebacks/ready; slave is the issue stage.
interface vx_issue_scoreboard_rr_if
    import vx_issue_scoreboard_rr_pkg::*;
#(
    parameter int NUM_WARPS     = DEF_NUM_WARPS,
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int NUM_WB        = DEF_NUM_WB,
    parameter int NUM_EX        = DEF_NUM_EX,
    parameter int DATAW         = DEF_DATAW,
    parameter int PERF_CTR_BITS = DEF_PERF_CTR_BITS
);
    localparam int RW   = $clog2(NUM_REGS);
    localparam int WIDW = clog2_min1(NUM_WARPS);
    localparam int EXW  = clog2_min1(NUM_EX);

    logic [NUM_WARPS-1:0]       in_valid;
    logic [NUM_WARPS-1:0]       in_ready;
    logic [NUM_WARPS-1:0]       in_wb;
    logic [NUM_WARPS*RW-1:0]    in_rd;
    logic [NUM_WARPS*RW-1:0]    in_rs1;
    logic [NUM_WARPS*RW-1:0]    in_rs2;
    logic [NUM_WARPS*RW-1:0]    in_rs3;
    logic [NUM_WARPS*EXW-1:0]   in_ex_type;
    logic [NUM_WARPS*DATAW-1:0] in_data;

    logic [NUM_WB-1:0]          wb_valid;
    logic [NUM_WB*WIDW-1:0]     wb_wid;
    logic [NUM_WB*RW-1:0]       wb_rd;
    logic [NUM_WB-1:0]          wb_eop;

    logic [NUM_EX-1:0]          out_valid;
    logic [NUM_EX-1:0]          out_ready;
    logic [WIDW-1:0]            out_wid;
    logic [DATAW-1:0]           out_data;

    logic [PERF_CTR_BITS-1:0]   perf_stalls;
    logic [PERF_CTR_BITS-1:0]   perf_issued;

    modport master (
        output in_valid, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_ex_type, in_data,
        output wb_valid, wb_wid, wb_rd, wb_eop, out_ready,
        input  in_ready, out_valid, out_wid, out_data, perf_stalls, perf_issued
    );

    modport slave (
        input  in_valid, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_ex_type, in_data,
        input  wb_valid, wb_wid, wb_rd, wb_eop, out_ready,
        output in_ready, out_valid, out_wid, out_data, perf_stalls, perf_issued
    );

endinterface

// File: rtl/vx_issue_scoreboard_rr_rr_arbiter.sv
// One-hot round-robin arbiter; priority starts at the internal pointer, which
// moves just past the winner on every grant.
module vx_rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    logic [PW-1:0] ptr_q;

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (|grant) begin
            ptr_q <= PW'((int'(grant_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/vx_issue_scoreboard_rr.sv
// Issue stage: per-warp register-pending scoreboard with same-cycle writeback
// bypass, round-robin warp pick and a registered dispatch slot steered by ex_type.
module vx_issue_scoreboard_rr
    import vx_issue_scoreboard_rr_pkg::*;
#(
    parameter int NUM_WARPS     = DEF_NUM_WARPS,
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int NUM_WB        = DEF_NUM_WB,
    parameter int NUM_EX        = DEF_NUM_EX,
    parameter int DATAW         = DEF_DATAW,
    parameter int PERF_CTR_BITS = DEF_PERF_CTR_BITS
) (
    input logic                    clk,
    input logic                    reset,
    vx_issue_scoreboard_rr_if.slave bus
);
    localparam int RW   = $clog2(NUM_REGS);
    localparam int WIDW = clog2_min1(NUM_WARPS);
    localparam int EXW  = clog2_min1(NUM_EX);

    typedef struct packed {
        logic             wb;
        logic [RW-1:0]    rd;
        logic [RW-1:0]    rs1;
        logic [RW-1:0]    rs2;
        logic [RW-1:0]    rs3;
        logic [EXW-1:0]   ex_type;
        logic [DATAW-1:0] data;
    } req_t;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_q, rel, pend_clr, set, pend_d;
    logic [NUM_WARPS-1:0]     hazard, eligible, grant;
    logic [WIDW-1:0]          grant_idx;
    logic [NUM_EX-1:0]        out_valid_q, ex_oh;
    logic [WIDW-1:0]          out_wid_q;
    logic [DATAW-1:0]         out_data_q;
    logic [PERF_CTR_BITS-1:0] perf_stalls_q, perf_issued_q;
    logic                     fire, load_ok;
    req_t                     reqs [NUM_WARPS];
    req_t                     sel;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            reqs[w].wb      = bus.in_wb[w];
            reqs[w].rd      = bus.in_rd[w*RW +: RW];
            reqs[w].rs1     = bus.in_rs1[w*RW +: RW];
            reqs[w].rs2     = bus.in_rs2[w*RW +: RW];
            reqs[w].rs3     = bus.in_rs3[w*RW +: RW];
            reqs[w].ex_type = bus.in_ex_type[w*EXW +: EXW];
            reqs[w].data    = bus.in_data[w*DATAW +: DATAW];
        end
    end

    // Writeback releases feed this cycle's hazard check as well as next state.
    always_comb begin
        logic [WIDW-1:0] wid;
        logic [RW-1:0]   rd;
        rel = '0;
        wid = '0;
        rd  = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            wid = bus.wb_wid[p*WIDW +: WIDW];
            rd  = bus.wb_rd[p*RW +: RW];
            if (bus.wb_valid[p] && bus.wb_eop[p] && int'(wid) < NUM_WARPS)
                rel[wid][rd] = 1'b1;
        end
    end

    assign pend_clr = pend_q & ~rel;

    always_comb begin
        logic [NUM_REGS-1:0] row;
        row    = '0;
        hazard = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            row       = pend_clr[w];
            hazard[w] = row[reqs[w].rs1] | row[reqs[w].rs2] | row[reqs[w].rs3]
                      | (reqs[w].wb & row[reqs[w].rd]);
        end
    end

    assign fire     = |(out_valid_q & bus.out_ready);
    assign load_ok  = ~(|out_valid_q) | fire;
    assign eligible = bus.in_valid & ~hazard & {NUM_WARPS{load_ok & ~reset}};

    vx_rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (eligible),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.in_ready = grant;
    assign sel          = reqs[grant_idx];

    always_comb begin
        ex_oh = '0;
        if (int'(sel.ex_type) < NUM_EX)
            ex_oh[sel.ex_type] = 1'b1;
    end

    // Index 0 is hardwired zero, so it is never marked pending.
    always_comb begin
        set = '0;
        if (|grant && sel.wb && sel.rd != '0)
            set[grant_idx][sel.rd] = 1'b1;
    end

    assign pend_d = pend_clr | set;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q        <= '0;
            out_valid_q   <= '0;
            out_wid_q     <= '0;
            out_data_q    <= '0;
            perf_stalls_q <= '0;
            perf_issued_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (|grant) begin
                out_valid_q <= ex_oh;
                out_wid_q   <= grant_idx;
                out_data_q  <= sel.data;
            end else if (fire) begin
                out_valid_q <= '0;
            end
            perf_stalls_q <= perf_stalls_q + PERF_CTR_BITS'((|bus.in_valid) & ~(|grant));
            perf_issued_q <= perf_issued_q + PERF_CTR_BITS'(|grant);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (bus.wb_valid[p] && bus.wb_eop[p])
                    assert (pend_q[bus.wb_wid[p*WIDW +: WIDW]][bus.wb_rd[p*RW +: RW]])
                        else $error("release of non-pending reg on wb port %0d", p);
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (bus.in_valid[w])
                    assert (int'(reqs[w].ex_type) < NUM_EX)
                        else $error("illegal ex_type on warp %0d", w);
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_wid     = out_wid_q;
    assign bus.out_data    = out_data_q;
    assign bus.perf_stalls = perf_stalls_q;
    assign bus.perf_issued = perf_issued_q;

endmodule

// File: tb/tb_vx_issue_scoreboard_rr.sv
// Directed bench for the scoreboarded round-robin issue stage.
module tb_vx_issue_scoreboard_rr;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vx_issue_scoreboard_rr_if bus ();

    vx_issue_scoreboard_rr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.in_valid   = '0;
        bus.in_wb      = '0;
        bus.in_rd      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_rs3     = '0;
        bus.in_ex_type = '0;
        bus.in_data    = '0;
        bus.wb_valid   = '0;
        bus.wb_wid     = '0;
        bus.wb_rd      = '0;
        bus.wb_eop     = '0;
    endtask

    task automatic set_warp(input int w, input logic wb, input logic [5:0] rd,
                            input logic [5:0] rs1, input logic [1:0] ex,
                            input logic [63:0] data);
        bus.in_valid[w]            = 1'b1;
        bus.in_wb[w]               = wb;
        bus.in_rd[w*6 +: 6]        = rd;
        bus.in_rs1[w*6 +: 6]       = rs1;
        bus.in_rs2[w*6 +: 6]       = '0;
        bus.in_rs3[w*6 +: 6]       = '0;
        bus.in_ex_type[w*2 +: 2]   = ex;
        bus.in_data[w*64 +: 64]    = data;
    endtask

    task automatic set_wb(input int p, input logic v, input logic [1:0] wid,
                          input logic [5:0] rd, input logic eop);
        bus.wb_valid[p]       = v;
        bus.wb_wid[p*2 +: 2]  = wid;
        bus.wb_rd[p*6 +: 6]   = rd;
        bus.wb_eop[p]         = eop;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        clear_in();
        bus.out_ready = 4'hF;
        reset = 1'b1;
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_pend", 64'(dut.pend_q), 64'h0);
        chk("rst_issued", 64'(bus.perf_issued), 64'h0);
        reset = 1'b0;

        // basic issue and RAW stall
        set_warp(0, 1'b1, 6'd5, 6'd0, 2'd1, 64'hA0);
        #1;
        chk("t1_in_ready", 64'(bus.in_ready), 64'h1);
        step();
        chk("t1_out_valid", 64'(bus.out_valid), 64'h2);
        chk("t1_out_data", bus.out_data, 64'hA0);
        chk("t1_pend05", 64'(dut.pend_q[0][5]), 64'h1);
        set_warp(0, 1'b0, 6'd0, 6'd5, 2'd2, 64'hB0);
        #1;
        chk("t1_stall_ready", 64'(bus.in_ready), 64'h0);
        step();
        chk("t1_drained", 64'(bus.out_valid), 64'h0);
        step();
        step();
        chk("t1_stalls", 64'(bus.perf_stalls), 64'd3);

        // writeback bypass, eop gating
        set_wb(0, 1'b1, 2'd0, 6'd5, 1'b0);
        #1;
        chk("t2_noeop_ready", 64'(bus.in_ready), 64'h0);
        step();
        set_wb(0, 1'b1, 2'd0, 6'd5, 1'b1);
        #1;
        chk("t2_bypass_ready", 64'(bus.in_ready), 64'h1);
        step();
        clear_in();
        chk("t2_pend05", 64'(dut.pend_q[0][5]), 64'h0);
        chk("t2_out_valid", 64'(bus.out_valid), 64'h4);
        chk("t2_out_data", bus.out_data, 64'hB0);
        chk("t2_stalls", 64'(bus.perf_stalls), 64'd4);
        chk("t2_issued", 64'(bus.perf_issued), 64'd2);

        // fresh start so the pointer begins at warp 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int w = 0; w < 4; w++)
            set_warp(w, 1'b0, 6'd0, 6'd0, 2'(w), 64'hC0 + 64'(w));
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t3_grant%0d", i), 64'(bus.in_ready), 64'(exp_grant[i]));
            step();
            chk($sformatf("t3_wid%0d", i), 64'(bus.out_wid), 64'(i % 4));
        end
        chk("t3_issued", 64'(bus.perf_issued), 64'd5);
        chk("t3_stalls", 64'(bus.perf_stalls), 64'd0);

        // backpressure on unit 0 holding warp0's instruction
        bus.out_ready = 4'h0;
        #1;
        chk("t4_blocked", 64'(bus.in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_hold_wid%0d", i), 64'(bus.out_wid), 64'h0);
            chk($sformatf("t4_hold_data%0d", i), bus.out_data, 64'hC0);
            chk($sformatf("t4_hold_ready%0d", i), 64'(bus.in_ready), 64'h0);
        end
        chk("t4_stalls", 64'(bus.perf_stalls), 64'd3);
        bus.out_ready = 4'h1;
        #1;
        chk("t4_fire_grant", 64'(bus.in_ready), 64'h2);
        step();
        chk("t4_new_wid", 64'(bus.out_wid), 64'h1);
        chk("t4_new_valid", 64'(bus.out_valid), 64'h2);
        clear_in();
        bus.out_ready = 4'hF;

        // set beats release on the same reg; rd=0 never pending
        set_warp(1, 1'b1, 6'd7, 6'd0, 2'd3, 64'hD0);
        step();
        chk("t5_pend17", 64'(dut.pend_q[1][7]), 64'h1);
        set_warp(1, 1'b1, 6'd7, 6'd0, 2'd3, 64'hD1);
        set_wb(1, 1'b1, 2'd1, 6'd7, 1'b1);
        #1;
        chk("t5_bypass_ready", 64'(bus.in_ready), 64'h2);
        step();
        clear_in();
        chk("t5_set_wins", 64'(dut.pend_q[1][7]), 64'h1);
        set_warp(2, 1'b1, 6'd0, 6'd0, 2'd0, 64'hE0);
        #1;
        chk("t5_rd0_ready", 64'(bus.in_ready), 64'h4);
        step();
        clear_in();
        chk("t5_rd0_pend", 64'(dut.pend_q[2]), 64'h0);

        // reset while busy
        chk("t6_pre_valid", 64'(bus.out_valid), 64'h1);
        reset = 1'b1;
        set_warp(0, 1'b0, 6'd0, 6'd0, 2'd0, 64'hF0);
        #1;
        chk("t6_ready_in_reset", 64'(bus.in_ready), 64'h0);
        step();
        chk("t6_out_valid", 64'(bus.out_valid), 64'h0);
        chk("t6_out_wid", 64'(bus.out_wid), 64'h0);
        chk("t6_out_data", bus.out_data, 64'h0);
        chk("t6_pend", 64'(dut.pend_q), 64'h0);
        chk("t6_ptr", 64'(dut.u_arb.ptr_q), 64'h0);
        chk("t6_stalls", 64'(bus.perf_stalls), 64'h0);
        chk("t6_issued", 64'(bus.perf_issued), 64'h0);
        reset = 1'b0;
        clear_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
